// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, NOP encoding and fetch FSM states
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and priority flush
module if_id_reg #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = load_pc;
      instr_d = load_instr;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_pc    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, fetch FSM, hold buffer and stall counter feeding IF/ID
module fetch_unit #(
  parameter int                      XLEN      = riscv_pkg::XLEN,
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]             NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic [15:0]     stall_count
);
  import riscv_pkg::*;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] START_PC   = XLEN'(RESET_PC) & ALIGN_MASK;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [31:0]     hold_buf_q, hold_buf_d;
  logic [15:0]     stall_count_q, stall_count_d;

  logic            advance;
  logic [XLEN-1:0] target_pc;
  logic            bubble;
  logic            load;
  logic [31:0]     load_instr;

  assign advance   = pc_write & if_id_write;
  assign target_pc = redirect_pc & ALIGN_MASK;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    hold_buf_d    = hold_buf_q;
    stall_count_d = stall_count_q;
    bubble        = 1'b0;
    load          = 1'b0;
    load_instr    = imem_rdata;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        pc_d    = START_PC;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d = target_pc;
          end else if (advance) begin
            load = 1'b1;
            pc_d = pc_q + XLEN'(4);
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          // the address must not move under an outstanding request
          pending_pc_d = target_pc;
          state_d      = DRAIN;
        end else if (if_id_write) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          hold_buf_d = '0;
          pc_d       = target_pc;
          state_d    = FETCH;
        end else if (advance) begin
          load       = 1'b1;
          load_instr = hold_buf_q;
          pc_d       = pc_q + XLEN'(4);
          state_d    = FETCH;
        end else if (stall_count_q != 16'hFFFF) begin
          stall_count_d = stall_count_q + 16'd1;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pending_pc_d = target_pc;
        end
        if (imem_ack) begin
          pc_d    = redirect_valid ? target_pc : pending_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= START_PC;
      pending_pc_q  <= '0;
      hold_buf_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      hold_buf_q    <= hold_buf_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign stall_count = stall_count_q;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid | bubble),
    .load        (load),
    .load_pc     (pc_q),
    .load_instr  (load_instr),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven directed bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b0;
  logic        if_id_write = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [15:0] stall_count;

  int n_run = 0;
  int n_fail = 0;

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic pw, logic iw, logic rv, logic [31:0] rpc,
                              logic ack, logic [31:0] rdata, logic e_req,
                              logic [31:0] e_addr, logic [31:0] e_pc,
                              logic [31:0] e_instr, logic e_valid, logic [15:0] e_stall);
    vec_t v;
    v.pw = pw; v.iw = iw; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_valid = e_valid; v.e_stall = e_stall;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                         input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic e_valid, input logic [15:0] e_stall);
    chk("imem_req", idx, 32'(imem_req), 32'(e_req));
    chk("imem_addr", idx, imem_addr, e_addr);
    chk("if_id_pc", idx, if_id_pc, e_pc);
    chk("if_id_instr", idx, if_id_instr, e_instr);
    chk("if_id_valid", idx, 32'(if_id_valid), 32'(e_valid));
    chk("stall_count", idx, 32'(stall_count), 32'(e_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //   pw iw rv rpc           ack rdata          | req addr          pc            instr         v  stall
    add(1, 1, 0, 32'h0,        0, 32'h0,          1, 32'h0,         32'h0,        NOP,          0, 16'd0);
    add(1, 1, 0, 32'h0,        1, 32'hA000_0000,  1, 32'h4,         32'h0,        32'hA000_0000, 1, 16'd0);
    add(1, 1, 0, 32'h0,        1, 32'hA000_0004,  1, 32'h8,         32'h4,        32'hA000_0004, 1, 16'd0);
    add(0, 0, 0, 32'h0,        1, 32'hA000_0008,  0, 32'h8,         32'h4,        32'hA000_0004, 1, 16'd0);
    add(0, 0, 0, 32'h0,        1, 32'hDEAD_BEEF,  0, 32'h8,         32'h4,        32'hA000_0004, 1, 16'd1);
    add(1, 0, 0, 32'h0,        0, 32'h0,          0, 32'h8,         32'h4,        32'hA000_0004, 1, 16'd2);
    add(0, 1, 0, 32'h0,        0, 32'h0,          0, 32'h8,         32'h4,        32'hA000_0004, 1, 16'd3);
    add(1, 1, 0, 32'h0,        0, 32'h0,          1, 32'hC,         32'h8,        32'hA000_0008, 1, 16'd3);
    add(1, 1, 0, 32'h0,        1, 32'hA000_000C,  1, 32'h10,        32'hC,        32'hA000_000C, 1, 16'd3);
    add(1, 1, 1, 32'h103,      1, 32'hA000_0010,  1, 32'h100,       32'h0,        NOP,          0, 16'd3);
    add(1, 1, 0, 32'h0,        0, 32'h0,          1, 32'h100,       32'h0,        NOP,          0, 16'd3);
    add(1, 1, 0, 32'h0,        1, 32'hA000_0100,  1, 32'h104,       32'h100,      32'hA000_0100, 1, 16'd3);
    add(0, 0, 1, 32'h20,       1, 32'hA000_0104,  1, 32'h20,        32'h0,        NOP,          0, 16'd3);
    add(1, 1, 1, 32'h300,      0, 32'h0,          1, 32'h20,        32'h0,        NOP,          0, 16'd3);
    add(1, 1, 1, 32'h200,      0, 32'h0,          1, 32'h20,        32'h0,        NOP,          0, 16'd3);
    add(1, 1, 0, 32'h0,        0, 32'h0,          1, 32'h20,        32'h0,        NOP,          0, 16'd3);
    add(1, 1, 0, 32'h0,        1, 32'hDEAD_BEEF,  1, 32'h200,       32'h0,        NOP,          0, 16'd3);
    add(1, 1, 0, 32'h0,        1, 32'hA000_0200,  1, 32'h204,       32'h200,      32'hA000_0200, 1, 16'd3);
    add(1, 1, 1, 32'hFFFF_FFFC, 1, 32'hA000_0204, 1, 32'hFFFF_FFFC, 32'h0,        NOP,          0, 16'd3);
    add(1, 1, 0, 32'h0,        1, 32'hA0FF_FFFC,  1, 32'h0,         32'hFFFF_FFFC, 32'hA0FF_FFFC, 1, 16'd3);
    add(1, 1, 0, 32'h0,        1, 32'hA000_0000,  1, 32'h4,         32'h0,        32'hA000_0000, 1, 16'd3);
    add(0, 0, 0, 32'h0,        1, 32'hA000_0004,  0, 32'h4,         32'h0,        32'hA000_0000, 1, 16'd3);
    add(0, 0, 0, 32'h0,        0, 32'h0,          0, 32'h4,         32'h0,        32'hA000_0000, 1, 16'd4);

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk_all(-1, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      pc_write       = vecs[i].pw;
      if_id_write    = vecs[i].iw;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      imem_ack       = vecs[i].ack;
      imem_rdata     = vecs[i].rdata;
      @(posedge clk); #1;
      chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr,
              vecs[i].e_valid, vecs[i].e_stall);
      @(negedge clk);
    end

    // asynchronous reset while HOLD has a buffered word
    pc_write = 1'b0; if_id_write = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_all(100, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 16'd0);
    @(posedge clk); #1;
    chk_all(101, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pc_write = 1'b1; if_id_write = 1'b1;
    @(posedge clk); #1;
    chk_all(102, 1'b1, 32'h0, 32'h0, NOP, 1'b0, 16'd0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk_all(103, 1'b1, 32'h4, 32'h0, 32'h1234_5678, 1'b1, 16'd0);
    @(negedge clk);
    imem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
